// File: rtl/conditioning_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conditioning_seq_pkg                                                       |
// | Mode and state encodings, and the board's default break-before-make mask.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package conditioning_seq_pkg;

    localparam logic [1:0] MODE_SAFE   = 2'd0;
    localparam logic [1:0] MODE_TEST   = 2'd1;
    localparam logic [1:0] MODE_SEQ    = 2'd2;
    localparam logic [1:0] MODE_DIRECT = 2'd3;

    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_MBREAK = 2'd1;
    localparam logic [1:0] c_ST_PBREAK = 2'd2;

    // Mux enable bits on the current board; these drop during inter-phase breaks.
    localparam int c_AZMUX_EN_BIT = 3;
    localparam int c_HIMUX_EN_BIT = 7;
    localparam logic [17:0] c_BBM_MASK_DEFAULT =
        (18'd1 << c_AZMUX_EN_BIT) | (18'd1 << c_HIMUX_EN_BIT);

endpackage
`default_nettype wire

// File: rtl/conditioning_seq_phase_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conditioning_seq_phase_table                                               |
// | Sequencer pattern/dwell register file: one write port, one async read.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module conditioning_seq_phase_table
    import conditioning_seq_pkg::*;
#(
    parameter int WIDTH      = 18,
    parameter int CNT_W      = 24,
    parameter int NUM_PHASES = 4,
    parameter int AW         = $clog2(NUM_PHASES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_pattern,
    input  logic [CNT_W-1:0] wr_dwell,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_pattern,
    output logic [CNT_W-1:0] rd_dwell
);

    logic [WIDTH-1:0] r_pattern [NUM_PHASES];
    logic [CNT_W-1:0] r_dwell   [NUM_PHASES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                r_pattern[i] <= '0;
                r_dwell[i]   <= CNT_W'(1);
            end
        end else if (wr_en) begin
            r_pattern[wr_addr] <= wr_pattern;
            r_dwell[wr_addr]   <= wr_dwell;
        end
    end

    // Same-cycle write and read of one entry returns the old contents.
    assign rd_pattern = r_pattern[rd_addr];
    assign rd_dwell   = r_dwell[rd_addr];

endmodule
`default_nettype wire

// File: rtl/conditioning_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conditioning_seq                                                           |
// | Conditioning output mux: safe / test counter / phase sequencer / direct,   |
// | with break-before-make on mode changes and between sequencer phases.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module conditioning_seq
    import conditioning_seq_pkg::*;
#(
    parameter int               WIDTH      = 18,
    parameter int               NUM_PHASES = 4,
    parameter int               CNT_W      = 24,
    parameter int               BBM_CYCLES = 2,
    parameter logic [WIDTH-1:0] BBM_MASK   = WIDTH'(c_BBM_MASK_DEFAULT),
    parameter logic [WIDTH-1:0] SAFE_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    mode,
    input  logic [WIDTH-1:0]              direct,
    input  logic [$clog2(NUM_PHASES)-1:0] seq_last,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_PHASES)-1:0] wr_addr,
    input  logic [WIDTH-1:0]              wr_pattern,
    input  logic [CNT_W-1:0]              wr_dwell,
    output logic [WIDTH-1:0]              out,
    output logic [$clog2(NUM_PHASES)-1:0] phase,
    output logic                          phase_strobe,
    output logic                          busy
);

    localparam int             PW           = $clog2(NUM_PHASES);
    localparam int             BW           = $clog2(BBM_CYCLES + 1);
    localparam logic [BW-1:0]  c_BRK_RELOAD = BW'(BBM_CYCLES - 1);

    logic [1:0]       r_state, w_state;
    logic [1:0]       r_active_mode, w_active_mode;
    logic [1:0]       r_target, w_target;
    logic [BW-1:0]    r_brk_cnt, w_brk_cnt;
    logic [CNT_W-1:0] r_dwell_cnt, w_dwell_cnt;
    logic [WIDTH-1:0] r_out, w_out;
    logic [PW-1:0]    r_phase, w_phase;
    logic [PW-1:0]    r_next_phase, w_next_phase;
    logic             r_strobe, w_strobe;
    logic             r_busy, w_busy;
    logic             w_load;

    logic [PW-1:0]    w_next;
    logic [PW-1:0]    w_rd_addr;
    logic [WIDTH-1:0] w_rd_pattern;
    logic [CNT_W-1:0] w_rd_dwell;
    logic [CNT_W-1:0] w_dwell_m1;

    assign w_next     = (r_phase >= seq_last) ? '0 : r_phase + PW'(1);
    assign w_rd_addr  = (r_state == c_ST_RUN)    ? w_next :
                        (r_state == c_ST_PBREAK) ? r_next_phase : '0;
    assign w_dwell_m1 = (w_rd_dwell == '0) ? '0 : w_rd_dwell - CNT_W'(1);

    conditioning_seq_phase_table #(
        .WIDTH      (WIDTH),
        .CNT_W      (CNT_W),
        .NUM_PHASES (NUM_PHASES),
        .AW         (PW)
    ) u_table (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_pattern (wr_pattern),
        .wr_dwell   (wr_dwell),
        .rd_addr    (w_rd_addr),
        .rd_pattern (w_rd_pattern),
        .rd_dwell   (w_rd_dwell)
    );

    always_comb begin
        w_state       = r_state;
        w_active_mode = r_active_mode;
        w_target      = r_target;
        w_brk_cnt     = r_brk_cnt;
        w_dwell_cnt   = r_dwell_cnt;
        w_out         = r_out;
        w_phase       = r_phase;
        w_next_phase  = r_next_phase;
        w_strobe      = 1'b0;
        w_busy        = r_busy;
        w_load        = 1'b0;

        case (r_state)
            c_ST_MBREAK: begin
                if (mode != r_target) begin
                    w_target  = mode;
                    w_brk_cnt = c_BRK_RELOAD;
                end else if (r_brk_cnt == '0) begin
                    // Leaving the break drives the new mode's first value immediately.
                    w_state       = c_ST_RUN;
                    w_active_mode = r_target;
                    w_busy        = 1'b0;
                    case (r_target)
                        MODE_TEST:   w_out = '0;
                        MODE_SEQ: begin
                            w_phase = '0;
                            w_load  = 1'b1;
                        end
                        MODE_DIRECT: w_out = direct;
                        default:     w_out = SAFE_VALUE;
                    endcase
                end else begin
                    w_brk_cnt = r_brk_cnt - BW'(1);
                end
            end

            c_ST_PBREAK: begin
                if (mode != r_active_mode) begin
                    w_state   = c_ST_MBREAK;
                    w_target  = mode;
                    w_brk_cnt = c_BRK_RELOAD;
                    w_out     = SAFE_VALUE;
                    w_busy    = 1'b1;
                end else if (r_brk_cnt == '0) begin
                    w_state = c_ST_RUN;
                    w_busy  = 1'b0;
                    w_phase = r_next_phase;
                    w_load  = 1'b1;
                end else begin
                    w_brk_cnt = r_brk_cnt - BW'(1);
                end
            end

            default: begin
                if (mode != r_active_mode) begin
                    w_state   = c_ST_MBREAK;
                    w_target  = mode;
                    w_brk_cnt = c_BRK_RELOAD;
                    w_out     = SAFE_VALUE;
                    w_busy    = 1'b1;
                end else begin
                    case (r_active_mode)
                        MODE_TEST:   w_out = r_out + WIDTH'(1);
                        MODE_DIRECT: w_out = direct;
                        MODE_SEQ: begin
                            if (r_dwell_cnt != '0) begin
                                w_dwell_cnt = r_dwell_cnt - CNT_W'(1);
                            end else if (w_rd_pattern == r_out || BBM_MASK == '0) begin
                                w_phase = w_next;
                                w_load  = 1'b1;
                            end else begin
                                // Compare and mask against the driven value, not the
                                // table, so a rewrite of this entry cannot glitch out.
                                w_state      = c_ST_PBREAK;
                                w_busy       = 1'b1;
                                w_brk_cnt    = c_BRK_RELOAD;
                                w_next_phase = w_next;
                                w_out        = r_out & ~BBM_MASK;
                            end
                        end
                        default:     w_out = SAFE_VALUE;
                    endcase
                end
            end
        endcase

        if (w_load) begin
            w_out       = w_rd_pattern;
            w_strobe    = 1'b1;
            w_dwell_cnt = w_dwell_m1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_RUN;
            r_active_mode <= MODE_SAFE;
            r_target      <= MODE_SAFE;
            r_brk_cnt     <= '0;
            r_dwell_cnt   <= '0;
            r_out         <= SAFE_VALUE;
            r_phase       <= '0;
            r_next_phase  <= '0;
            r_strobe      <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_active_mode <= w_active_mode;
            r_target      <= w_target;
            r_brk_cnt     <= w_brk_cnt;
            r_dwell_cnt   <= w_dwell_cnt;
            r_out         <= w_out;
            r_phase       <= w_phase;
            r_next_phase  <= w_next_phase;
            r_strobe      <= w_strobe;
            r_busy        <= w_busy;
        end
    end

    assign out          = r_out;
    assign phase        = r_phase;
    assign phase_strobe = r_strobe;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_conditioning_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_conditioning_seq                                                        |
// | Directed vector table plus hand-written corner sequences.                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_conditioning_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic [17:0] direct;
    logic [1:0]  seq_last;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [17:0] wr_pattern;
    logic [23:0] wr_dwell;
    logic [17:0] out;
    logic [1:0]  phase;
    logic        phase_strobe;
    logic        busy;

    // Narrow instance for the counter wrap check.
    logic        reset2;
    logic [1:0]  mode2;
    logic [3:0]  out2;
    logic        phase2;
    logic        strobe2;
    logic        busy2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    conditioning_seq dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .direct       (direct),
        .seq_last     (seq_last),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_pattern   (wr_pattern),
        .wr_dwell     (wr_dwell),
        .out          (out),
        .phase        (phase),
        .phase_strobe (phase_strobe),
        .busy         (busy)
    );

    conditioning_seq #(
        .WIDTH      (4),
        .NUM_PHASES (2),
        .CNT_W      (4),
        .BBM_CYCLES (1),
        .BBM_MASK   (4'h8),
        .SAFE_VALUE (4'h0)
    ) dut2 (
        .clk          (clk),
        .reset        (reset2),
        .mode         (mode2),
        .direct       (4'h0),
        .seq_last     (1'b0),
        .wr_en        (1'b0),
        .wr_addr      (1'b0),
        .wr_pattern   (4'h0),
        .wr_dwell     (4'h0),
        .out          (out2),
        .phase        (phase2),
        .phase_strobe (strobe2),
        .busy         (busy2)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [17:0] direct;
        logic [17:0] out;
        logic        busy;
        logic        strobe;
        logic [1:0]  phase;
    } vec_t;

    vec_t vecs [26];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [17:0] p, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = a; wr_pattern = p; wr_dwell = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic chk_seq(input string name, input logic [17:0] o, input logic b,
                           input logic s, input logic [1:0] ph);
        chk({name, ".out"},    32'(out), 32'(o));
        chk({name, ".busy"},   32'(busy), 32'(b));
        chk({name, ".strobe"}, 32'(phase_strobe), 32'(s));
        chk({name, ".phase"},  32'(phase), 32'(ph));
    endtask

    initial begin
        // mode, direct, out, busy, strobe, phase
        vecs[0]  = '{2'd3, 18'h2A5A5, 18'h00000, 1'b1, 1'b0, 2'd0};
        vecs[1]  = '{2'd3, 18'h2A5A5, 18'h00000, 1'b1, 1'b0, 2'd0};
        vecs[2]  = '{2'd3, 18'h2A5A5, 18'h2A5A5, 1'b0, 1'b0, 2'd0};
        vecs[3]  = '{2'd3, 18'h12345, 18'h12345, 1'b0, 1'b0, 2'd0};
        vecs[4]  = '{2'd1, 18'h00000, 18'h00000, 1'b1, 1'b0, 2'd0};
        vecs[5]  = '{2'd1, 18'h00000, 18'h00000, 1'b1, 1'b0, 2'd0};
        vecs[6]  = '{2'd1, 18'h00000, 18'h00000, 1'b0, 1'b0, 2'd0};
        vecs[7]  = '{2'd1, 18'h00000, 18'h00001, 1'b0, 1'b0, 2'd0};
        vecs[8]  = '{2'd1, 18'h00000, 18'h00002, 1'b0, 1'b0, 2'd0};
        vecs[9]  = '{2'd1, 18'h00000, 18'h00003, 1'b0, 1'b0, 2'd0};
        vecs[10] = '{2'd1, 18'h00000, 18'h00004, 1'b0, 1'b0, 2'd0};
        vecs[11] = '{2'd2, 18'h00000, 18'h00000, 1'b1, 1'b0, 2'd0};
        vecs[12] = '{2'd2, 18'h00000, 18'h00000, 1'b1, 1'b0, 2'd0};
        vecs[13] = '{2'd2, 18'h00000, 18'h00018, 1'b0, 1'b1, 2'd0};
        vecs[14] = '{2'd2, 18'h00000, 18'h00018, 1'b0, 1'b0, 2'd0};
        vecs[15] = '{2'd2, 18'h00000, 18'h00018, 1'b0, 1'b0, 2'd0};
        vecs[16] = '{2'd2, 18'h00000, 18'h00010, 1'b1, 1'b0, 2'd0};
        vecs[17] = '{2'd2, 18'h00000, 18'h00010, 1'b1, 1'b0, 2'd0};
        vecs[18] = '{2'd2, 18'h00000, 18'h0009A, 1'b0, 1'b1, 2'd1};
        vecs[19] = '{2'd2, 18'h00000, 18'h0009A, 1'b0, 1'b0, 2'd1};
        vecs[20] = '{2'd2, 18'h00000, 18'h00012, 1'b1, 1'b0, 2'd1};
        vecs[21] = '{2'd2, 18'h00000, 18'h00012, 1'b1, 1'b0, 2'd1};
        vecs[22] = '{2'd2, 18'h00000, 18'h00018, 1'b0, 1'b1, 2'd0};
        vecs[23] = '{2'd2, 18'h00000, 18'h00018, 1'b0, 1'b0, 2'd0};
        vecs[24] = '{2'd2, 18'h00000, 18'h00018, 1'b0, 1'b0, 2'd0};
        vecs[25] = '{2'd2, 18'h00000, 18'h00010, 1'b1, 1'b0, 2'd0};

        reset = 1'b1; mode = 2'd0; direct = '0; seq_last = 2'd1;
        wr_en = 1'b0; wr_addr = '0; wr_pattern = '0; wr_dwell = '0;
        reset2 = 1'b1; mode2 = 2'd0;
        step(); step();
        chk_seq("reset", 18'h0, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;

        wr(2'd0, 18'h00018, 24'd3);
        wr(2'd1, 18'h0009A, 24'd2);

        for (int i = 0; i < 26; i++) begin
            mode = vecs[i].mode; direct = vecs[i].direct;
            step();
            chk_seq($sformatf("vec%0d", i), vecs[i].out, vecs[i].busy,
                    vecs[i].strobe, vecs[i].phase);
        end

        // Reset in the middle of an inter-phase break.
        reset = 1'b1;
        step();
        chk_seq("rst_pbreak", 18'h0, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;

        // Cleared table: patterns 0, dwell 1 -> phase advances every clock, no break.
        mode = 2'd2; seq_last = 2'd1;
        step(); step(); step();
        chk_seq("clr0", 18'h0, 1'b0, 1'b1, 2'd0);
        step();
        chk_seq("clr1", 18'h0, 1'b0, 1'b1, 2'd1);
        step();
        chk_seq("clr2", 18'h0, 1'b0, 1'b1, 2'd0);

        // Identical patterns skip the break; dwell 0 acts as 1; seq_last 0 repeats phase 0.
        mode = 2'd0;
        step(); step(); step();
        wr(2'd0, 18'h00055, 24'd2);
        wr(2'd1, 18'h00055, 24'd0);
        mode = 2'd2;
        step(); step(); step();
        chk_seq("same0", 18'h55, 1'b0, 1'b1, 2'd0);
        step();
        chk_seq("same1", 18'h55, 1'b0, 1'b0, 2'd0);
        step();
        chk_seq("same2", 18'h55, 1'b0, 1'b1, 2'd1);
        step();
        chk_seq("same3", 18'h55, 1'b0, 1'b1, 2'd0);
        seq_last = 2'd0;
        step();
        chk_seq("last0a", 18'h55, 1'b0, 1'b0, 2'd0);
        step();
        chk_seq("last0b", 18'h55, 1'b0, 1'b1, 2'd0);
        step();
        chk_seq("last0c", 18'h55, 1'b0, 1'b0, 2'd0);
        step();
        chk_seq("last0d", 18'h55, 1'b0, 1'b1, 2'd0);

        // Mode 2 -> 3 -> 1 while the break is running restarts it.
        mode = 2'd3;
        step();
        chk_seq("tog0", 18'h0, 1'b1, 1'b0, 2'd0);
        mode = 2'd1;
        step();
        chk_seq("tog1", 18'h0, 1'b1, 1'b0, 2'd0);
        step();
        chk_seq("tog2", 18'h0, 1'b1, 1'b0, 2'd0);
        step();
        chk_seq("tog3", 18'h0, 1'b0, 1'b0, 2'd0);
        step();
        chk_seq("tog4", 18'h1, 1'b0, 1'b0, 2'd0);

        // Write to the driven phase has no effect until reload; then reset mid-dwell.
        wr(2'd0, 18'h00018, 24'd1);
        wr(2'd1, 18'h0009A, 24'd6);
        seq_last = 2'd1; mode = 2'd2;
        step(); step(); step();
        chk_seq("md0", 18'h18, 1'b0, 1'b1, 2'd0);
        step();
        chk_seq("md1", 18'h10, 1'b1, 1'b0, 2'd0);
        step();
        step();
        chk_seq("md2", 18'h9A, 1'b0, 1'b1, 2'd1);
        wr(2'd1, 18'h3FFFF, 24'd6);
        chk_seq("md3", 18'h9A, 1'b0, 1'b0, 2'd1);
        step();
        reset = 1'b1;
        step();
        chk_seq("rst_dwell", 18'h0, 1'b0, 1'b0, 2'd0);
        reset = 1'b0; mode = 2'd0;

        // Counter wrap on the narrow instance.
        reset2 = 1'b0; mode2 = 2'd1;
        step();
        chk("wrap.busy", 32'(busy2), 32'd1);
        step();
        chk("wrap.start", 32'(out2), 32'd0);
        for (int i = 1; i < 16; i++) step();
        chk("wrap.max", 32'(out2), 32'hF);
        step();
        chk("wrap.zero", 32'(out2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
